// File: rtl/bcd_display_mux.sv
// bcd_display_mux: time-multiplexed driver for a 4-anode common-anode 7-segment
// display showing an 8-bit packed BCD value (tens [7:4], units [3:0]).
// The input value is shadowed once per scan frame so a digit pair is always
// taken from one sample. Each slot starts with GUARD cycles of all anodes off
// to suppress ghosting. Slots 2 and 3 stay dark so each digit keeps a 1/4 duty.
module bcd_display_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16,
  parameter int LZB         = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] Count,
  input  logic       Freeze,
  output logic [3:0] AN,
  output logic [6:0] SEG
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  logic [CW-1:0] cnt;
  logic [1:0]    slot;
  logic [7:0]    shadow;
  logic          load;
  logic          in_guard;
  logic [3:0]    an_d;
  logic [6:0]    seg_d;

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-decimal nibbles show a dash.
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // The last cycle of slot 3 is the frame boundary where a new value is taken.
  assign load = (slot == 2'd3) && (cnt == CNT_MAX);

  // Refresh counter and slot index; slot advances when the counter wraps.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt  <= '0;
      slot <= 2'd0;
    end else if (cnt == CNT_MAX) begin
      cnt  <= '0;
      slot <= slot + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Frame shadow: sampled only at the frame boundary, held while Freeze is high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shadow <= 8'h00;
    end else if (load && !Freeze) begin
      shadow <= Count;
    end
  end

  // Next anode/segment value from the current slot, counter and shadow.
  always_comb begin
    an_d     = AN_OFF;
    seg_d    = SEG_OFF;
    in_guard = (GUARD > 0) && (cnt < GUARD_C);
    if (!in_guard) begin
      case (slot)
        2'd0: begin
          an_d  = 4'b1110;
          seg_d = enc(shadow[3:0]);
        end
        2'd1: begin
          an_d = 4'b1101;
          // A dash (non-BCD tens) is always shown; only a true zero is blanked.
          if ((LZB != 0) && (shadow[7:4] == 4'd0)) begin
            seg_d = SEG_OFF;
          end else begin
            seg_d = enc(shadow[7:4]);
          end
        end
        default: begin
          an_d  = AN_OFF;
          seg_d = SEG_OFF;
        end
      endcase
    end
  end

  // Registered display outputs, one cycle behind the scan state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      AN  <= AN_OFF;
      SEG <= SEG_OFF;
    end else begin
      AN  <= an_d;
      SEG <= seg_d;
    end
  end

endmodule

// File: tb/tb_bcd_display_mux.sv
// Bench for bcd_display_mux: two instances (guarded with blanking, and
// unguarded without blanking) share stimulus; a frame-position model predicts
// the display and a monitor compares each cycle against the expected queue.
module tb_bcd_display_mux;

  localparam int RD = 8;
  localparam int FRAME = 4 * RD;

  logic       clk;
  logic       rst;
  logic [7:0] count;
  logic       freeze;
  logic [3:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;

  logic [21:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // model state: position within frame (0..31) and the value being displayed
  int         m_pos = 0;
  logic [7:0] m_shadow = 8'h00;

  bcd_display_mux #(.REFRESH_DIV(RD), .GUARD(2), .LZB(1)) dut_a (
    .CLK(clk), .RST(rst), .Count(count), .Freeze(freeze), .AN(an_a), .SEG(seg_a)
  );

  bcd_display_mux #(.REFRESH_DIV(RD), .GUARD(0), .LZB(0)) dut_b (
    .CLK(clk), .RST(rst), .Count(count), .Freeze(freeze), .AN(an_b), .SEG(seg_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // digit glyph table, active-low {g..a}
  function automatic logic [6:0] glyph(input int d);
    logic [6:0] t[10];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (d > 9) return 7'h3F;
    return t[d];
  endfunction

  // what the display should show given a frame position and displayed value
  function automatic logic [10:0] view(input int pos, input logic [7:0] val,
                                       input int guard, input int lzb);
    int slot, c, tens, units;
    slot  = pos / RD;
    c     = pos % RD;
    tens  = int'(val) / 16;
    units = int'(val) % 16;
    if (c < guard) return {4'b1111, 7'h7F};
    if (slot == 0) return {4'b1110, glyph(units)};
    if (slot == 1) begin
      if (tens == 0 && lzb == 1) return {4'b1101, 7'h7F};
      return {4'b1101, glyph(tens)};
    end
    return {4'b1111, 7'h7F};
  endfunction

  // reference model: on each edge predict the output that edge produces
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_q.push_back({4'b1111, 7'h7F, 4'b1111, 7'h7F});
        m_pos    = 0;
        m_shadow = 8'h00;
      end else begin
        exp_q.push_back({view(m_pos, m_shadow, 2, 1), view(m_pos, m_shadow, 0, 0)});
        if (m_pos == FRAME - 1 && !freeze) m_shadow = count;
        m_pos = (m_pos + 1) % FRAME;
      end
    end
  end

  // monitor / scoreboard
  initial begin
    logic [21:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({an_a, seg_a, an_b, seg_b} !== e) begin
          errors++;
          $display("FAIL display t=%0t got a:AN=%b SEG=%h b:AN=%b SEG=%h exp a:AN=%b SEG=%h b:AN=%b SEG=%h",
                   $time, an_a, seg_a, an_b, seg_b, e[21:18], e[17:11], e[10:7], e[6:0]);
        end
      end
    end
  end

  // driver tasks (inputs change on the falling edge)
  task automatic run(input int n, input logic [7:0] c, input logic f);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      count  = c;
      freeze = f;
    end
  endtask

  task automatic wait_pos(input int p);
    int k;
    k = 0;
    @(negedge clk);
    while (m_pos != p && k < 2 * FRAME) begin
      @(negedge clk);
      k++;
    end
    if (m_pos != p) begin
      errors++;
      $display("FAIL wait_pos timeout got %0d exp %0d", m_pos, p);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // stimulus
  initial begin
    rst    = 1'b1;
    count  = 8'h00;
    freeze = 1'b0;
    run(3, 8'h00, 1'b0);
    rst = 1'b0;
    // zero held, blanked tens
    run(2 * FRAME, 8'h00, 1'b0);
    // 57 applied mid-frame, appears after the next boundary
    run(12, 8'h00, 1'b0);
    run(2 * FRAME, 8'h57, 1'b0);
    // toggling value: only the boundary sample is shown
    for (int i = 0; i < 3 * FRAME; i++) run(1, (i % 2) ? 8'h34 : 8'h12, 1'b0);
    run(FRAME, 8'h57, 1'b0);
    // freeze across a boundary, then release
    run(2 * FRAME, 8'h99, 1'b1);
    run(2 * FRAME, 8'h99, 1'b0);
    // dashes and leading zero
    run(2 * FRAME, 8'h0A, 1'b0);
    run(2 * FRAME, 8'hA0, 1'b0);
    run(2 * FRAME, 8'h05, 1'b0);
    run(2 * FRAME, 8'hFF, 1'b0);
    // reset mid-slot (slot 1, cnt 5)
    count = 8'h68;
    wait_pos(RD + 5);
    pulse_reset();
    run(2 * FRAME, 8'h68, 1'b0);
    // reset coincident with the load edge
    count = 8'h42;
    wait_pos(FRAME - 1);
    pulse_reset();
    run(2 * FRAME, 8'h42, 1'b0);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      run(1, 8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      else rst = 1'b0;
    end
    rst = 1'b0;
    run(4, 8'h00, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
